// File: rtl/vga_timing_pipe.sv
// Parametrised VGA timing generator with frame-buffer address output, latency-matched
// sync/blank pipeline and runtime-selectable test patterns (bars, checkerboard, solid).
module vga_timing_pipe #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int DATA_LAT = 1,
    parameter int CW       = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            pix_en,
    input  logic [1:0]      mode,
    input  logic [3*CW-1:0] d_in,
    output logic [9:0]      col_addr,
    output logic [9:0]      row_addr,
    output logic            rd_en,
    output logic            hs,
    output logic            vs,
    output logic [CW-1:0]   r,
    output logic [CW-1:0]   g,
    output logic [CW-1:0]   b,
    output logic            frame_start
);

    localparam int PW    = 5 + 3*CW;
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    localparam logic [10:0] H_ACT_L  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS_L   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE_L   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST_L = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_ACT_L  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS_L   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE_L   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST_L = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] BAR_L    = 11'(BAR_W);
    localparam logic        HS_ON    = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic        VS_ON    = (VS_POL != 0) ? 1'b1 : 1'b0;

    function automatic logic [3*CW-1:0] expand_mask(input logic [2:0] m);
        return {{CW{m[2]}}, {CW{m[1]}}, {CW{m[0]}}};
    endfunction

    logic [9:0]      h_cnt_r, v_cnt_r, h_nxt_s, v_nxt_s;
    logic [10:0]     h_ext_s, v_ext_s, bar_idx_s;
    logic            h_last_s, v_last_s, at_origin_s;
    logic [1:0]      mode_q_r, mode_eff_s, mode_d_s;
    logic [3*CW-1:0] solid_q_r, solid_eff_s, pat_s, pat_d_s, pix_sel_s, rgb_r;
    logic [2:0]      bar_mask_s;
    logic            rd_en_s, hs_raw_s, vs_raw_s, act_d_s, hs_d_s, vs_d_s;
    logic            frame_start_r, hs_r, vs_r;
    logic [PW-1:0]   pipe_in_s, pipe_out_s;

    // Counter next-state, region decode and frame-boundary mode selection
    always_comb begin
        h_ext_s     = {1'b0, h_cnt_r};
        v_ext_s     = {1'b0, v_cnt_r};
        h_last_s    = (h_ext_s == H_LAST_L);
        v_last_s    = (v_ext_s == V_LAST_L);
        at_origin_s = (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
        h_nxt_s     = h_last_s ? 10'd0 : h_cnt_r + 10'd1;
        v_nxt_s     = v_cnt_r;
        if (h_last_s) begin
            v_nxt_s = v_last_s ? 10'd0 : v_cnt_r + 10'd1;
        end else begin
            v_nxt_s = v_cnt_r;
        end
        rd_en_s     = (h_ext_s < H_ACT_L) && (v_ext_s < V_ACT_L);
        hs_raw_s    = (h_ext_s >= H_SS_L) && (h_ext_s < H_SE_L);
        vs_raw_s    = (v_ext_s >= V_SS_L) && (v_ext_s < V_SE_L);
        // The origin tick itself already uses the newly sampled mode and solid colour
        mode_eff_s  = at_origin_s ? mode : mode_q_r;
        solid_eff_s = at_origin_s ? d_in : solid_q_r;
    end

    // Test-pattern generation; mode 0 data is picked up after the latency pipeline
    always_comb begin
        bar_idx_s = h_ext_s / BAR_L;
        case (bar_idx_s)
            11'd0:   bar_mask_s = 3'b111;
            11'd1:   bar_mask_s = 3'b110;
            11'd2:   bar_mask_s = 3'b011;
            11'd3:   bar_mask_s = 3'b010;
            11'd4:   bar_mask_s = 3'b101;
            11'd5:   bar_mask_s = 3'b100;
            11'd6:   bar_mask_s = 3'b001;
            default: bar_mask_s = 3'b000;
        endcase
        case (mode_eff_s)
            2'd1:    pat_s = expand_mask(bar_mask_s);
            2'd2:    pat_s = (h_cnt_r[4] ^ v_cnt_r[4]) ? expand_mask(3'b111) : '0;
            2'd3:    pat_s = solid_eff_s;
            default: pat_s = '0;
        endcase
    end

    // Timing counters, frame-latched mode/solid colour and frame_start pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt_r       <= 10'd0;
            v_cnt_r       <= 10'd0;
            mode_q_r      <= 2'd0;
            solid_q_r     <= '0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= pix_en & h_last_s & v_last_s;
            if (pix_en) begin
                h_cnt_r <= h_nxt_s;
                v_cnt_r <= v_nxt_s;
                if (at_origin_s) begin
                    mode_q_r  <= mode;
                    solid_q_r <= d_in;
                end
            end
        end
    end

    assign pipe_in_s = {rd_en_s, hs_raw_s, vs_raw_s, mode_eff_s, pat_s};

    generate
        if (DATA_LAT == 0) begin : g_nolat
            assign pipe_out_s = pipe_in_s;
        end else begin : g_lat
            logic [PW-1:0] pipe_r [DATA_LAT];
            // Delay line matching the frame-buffer read latency
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 0; i < DATA_LAT; i++) pipe_r[i] <= '0;
                end else if (pix_en) begin
                    pipe_r[0] <= pipe_in_s;
                    for (int i = 1; i < DATA_LAT; i++) pipe_r[i] <= pipe_r[i-1];
                end
            end
            assign pipe_out_s = pipe_r[DATA_LAT-1];
        end
    endgenerate

    assign act_d_s   = pipe_out_s[PW-1];
    assign hs_d_s    = pipe_out_s[PW-2];
    assign vs_d_s    = pipe_out_s[PW-3];
    assign mode_d_s  = pipe_out_s[PW-4:PW-5];
    assign pat_d_s   = pipe_out_s[3*CW-1:0];
    assign pix_sel_s = (mode_d_s == 2'd0) ? d_in : pat_d_s;

    // Output register stage: polarity applied, blanking forces black
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hs_r  <= ~HS_ON;
            vs_r  <= ~VS_ON;
            rgb_r <= '0;
        end else if (pix_en) begin
            hs_r  <= hs_d_s ? HS_ON : ~HS_ON;
            vs_r  <= vs_d_s ? VS_ON : ~VS_ON;
            rgb_r <= act_d_s ? pix_sel_s : '0;
        end
    end

    assign col_addr    = h_cnt_r;
    assign row_addr    = v_cnt_r;
    assign rd_en       = rd_en_s;
    assign hs          = hs_r;
    assign vs          = vs_r;
    assign r           = rgb_r[3*CW-1:2*CW];
    assign g           = rgb_r[2*CW-1:CW];
    assign b           = rgb_r[CW-1:0];
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench for vga_timing_pipe on a reduced 80x46 raster (66x40 visible, 8-pixel bars).
module tb_vga_timing_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pix_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [11:0] d_in = 12'hE12;
    logic [9:0]  col_addr, row_addr;
    logic        rd_en, hs, vs, frame_start;
    logic [3:0]  r, g, b;

    int checks = 0;
    int failures = 0;
    int gap = 0;
    bit rom_on = 1'b0;
    logic [11:0] bar_c [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                               12'hF0F, 12'hF00, 12'h00F, 12'h000};

    vga_timing_pipe #(
        .H_ACTIVE(66), .H_FP(4), .H_SYNC(8), .H_BP(2),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(0), .VS_POL(0), .DATA_LAT(1), .CW(4)
    ) dut (
        .clk(clk), .rstn(rstn), .pix_en(pix_en), .mode(mode), .d_in(d_in),
        .col_addr(col_addr), .row_addr(row_addr), .rd_en(rd_en),
        .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom(input logic [9:0] c, input logic [9:0] rr);
        return {c[3:0], rr[3:0], c[7:4] ^ 4'h9};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one pix_en tick; ROM answers with one tick of latency
    task automatic tick();
        logic [11:0] nxt;
        repeat (gap) begin @(posedge clk); #1; end
        nxt = rom(col_addr, row_addr);
        pix_en = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        if (rom_on) d_in = nxt;
    endtask

    task automatic goto(input int c, input int rr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (col_addr == 10'(c) && row_addr == 10'(rr)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) chk("goto_timeout", 32'd0, 32'd1);
    endtask

    task automatic pix_at(input int c, input int rr);
        goto(c, rr);
        tick();
        tick();
    endtask

    initial begin
        int lows, first, vlows, fs_cnt;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_rgb", {r, g, b}, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_col", col_addr, 0);
        rstn = 1'b1;
        chk("rel_addr", {col_addr, row_addr}, 0);
        tick();
        chk("tick1_col", col_addr, 1);
        chk("tick1_rgb", {r, g, b}, 0);
        tick();
        chk("first_pix", {r, g, b}, 12'hE12);
        chk("first_hs", hs, 1);

        pix_at(64, 0);
        chk("m0_c64", {r, g, b}, 12'hE12);
        tick();
        chk("m0_c65", {r, g, b}, 12'hE12);
        tick();
        chk("m0_porch", {r, g, b}, 0);

        goto(0, 1);
        lows = 0; first = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (hs == 1'b0) begin
                lows++;
                if (first < 0) first = i;
            end
        end
        chk("hs_low_ticks", lows, 8);
        chk("hs_fall_tick", first, 72);

        goto(65, 39);
        chk("rd_en_in", rd_en, 1);
        tick();
        chk("rd_en_out", rd_en, 0);
        goto(0, 42);
        chk("vs_before", vs, 1);
        tick();
        tick();
        chk("vs_active", vs, 0);
        chk("vs_blank", {r, g, b}, 0);

        goto(0, 0);
        vlows = 0; fs_cnt = 0;
        for (int i = 0; i < 3680; i++) begin
            tick();
            if (vs == 1'b0) vlows++;
            if (frame_start) fs_cnt++;
        end
        chk("vs_low_ticks", vlows, 160);
        chk("fs_per_frame", fs_cnt, 1);
        chk("frame_wrap", {col_addr, row_addr}, 0);

        goto(0, 10);
        mode = 2'd1;
        pix_at(8, 20);
        chk("no_tear", {r, g, b}, 12'hE12);
        goto(79, 45);
        tick();
        chk("fs_pulse", frame_start, 1);
        tick();
        tick();
        chk("bar0_c0", {r, g, b}, bar_c[0]);
        for (int k = 1; k < 8; k++) begin
            pix_at(k * 8 - 1, 0);
            chk("bar_edge_lo", {r, g, b}, 32'(bar_c[k-1]));
            tick();
            chk("bar_edge_hi", {r, g, b}, 32'(bar_c[k]));
        end
        pix_at(64, 5);
        chk("bar_beyond", {r, g, b}, 0);

        mode = 2'd2;
        pix_at(10, 30);
        chk("bar_hold", {r, g, b}, 12'hFF0);
        goto(0, 0);
        pix_at(15, 0);
        chk("chk_15_0", {r, g, b}, 0);
        tick();
        chk("chk_16_0", {r, g, b}, 12'hFFF);
        pix_at(31, 0);
        chk("chk_31_0", {r, g, b}, 12'hFFF);
        tick();
        chk("chk_32_0", {r, g, b}, 0);
        pix_at(0, 16);
        chk("chk_0_16", {r, g, b}, 12'hFFF);
        pix_at(16, 16);
        chk("chk_16_16", {r, g, b}, 0);
        pix_at(2, 20);
        repeat (20) @(posedge clk);
        #1;
        chk("freeze_addr", {col_addr, row_addr}, {10'd4, 10'd20});
        chk("freeze_rgb", {r, g, b}, 12'hFFF);
        chk("freeze_hs", hs, 1);

        gap = 3;
        goto(79, 45);
        tick();
        chk("fs_gap_hi", frame_start, 1);
        @(posedge clk); #1;
        chk("fs_gap_lo", frame_start, 0);
        gap = 0;

        mode = 2'd3;
        d_in = 12'h5A3;
        tick();
        d_in = 12'h000;
        tick();
        chk("solid_0_0", {r, g, b}, 12'h5A3);
        pix_at(20, 5);
        chk("solid_20_5", {r, g, b}, 12'h5A3);
        pix_at(10, 41);
        chk("solid_porch", {r, g, b}, 0);

        mode = 2'd0;
        rom_on = 1'b1;
        goto(0, 0);
        pix_at(5, 3);
        chk("rom_5_3", {r, g, b}, 32'(rom(10'd5, 10'd3)));
        pix_at(37, 20);
        chk("rom_37_20", {r, g, b}, 32'(rom(10'd37, 10'd20)));

        pix_at(30, 20);
        chk("pre_rst_rgb", {r, g, b}, 32'(rom(10'd30, 10'd20)));
        rstn = 1'b0;
        #1;
        chk("arst_rgb", {r, g, b}, 0);
        chk("arst_addr", {col_addr, row_addr}, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();
        chk("rel_col", {col_addr, row_addr}, {10'd1, 10'd0});
        tick();
        chk("rel_pix", {r, g, b}, 32'(rom(10'd0, 10'd0)));
        goto(74, 20);
        chk("pre_rst_hs", hs, 0);
        rstn = 1'b0;
        #1;
        chk("arst_hs", hs, 1);
        chk("arst_vs", vs, 1);
        rstn = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
